// File: rtl/ibex_cx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ibex_cx_ctrl_pkg                                            |
// | Brief  : Shared CSR numbers, opcodes, states and helpers for CX ctrl |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ibex_cx_ctrl_pkg;

  localparam logic [11:0] CSR_CX_IDX   = 12'h800;
  localparam logic [11:0] CSR_CX_STAT  = 12'h801;
  localparam logic [11:0] CSR_MCX_IDX  = 12'hBC0;
  localparam logic [11:0] CSR_MCX_EN   = 12'hBC1;

  localparam logic [6:0]  OPCODE_CX0   = 7'h0b;
  localparam logic [6:0]  OPCODE_CX1   = 7'h2b;
  localparam logic [6:0]  OPCODE_CX2   = 7'h5b;

  localparam logic [1:0]  CSR_OP_NONE  = 2'd0;
  localparam logic [1:0]  CSR_OP_WRITE = 2'd1;
  localparam logic [1:0]  CSR_OP_SET   = 2'd2;
  localparam logic [1:0]  CSR_OP_CLEAR = 2'd3;

  localparam logic [1:0]  PRIV_LVL_M   = 2'b11;

  localparam int CX_STAT_BUSY     = 0;
  localparam int CX_STAT_ERR_DIS  = 1;
  localparam int CX_STAT_ERR_TO   = 2;
  localparam int CX_STAT_ERR_RESP = 3;

  localparam int CX_IDX_ID_W    = 8;
  localparam int CX_IDX_STATE_W = 8;
  localparam int CX_IDX_W       = CX_IDX_ID_W + CX_IDX_STATE_W;

  typedef enum logic [1:0] {
    CX_IDLE = 2'd0,
    CX_WAIT = 2'd1,
    CX_DONE = 2'd2
  } cx_state_e;

  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: csr_apply = wdata;
      CSR_OP_SET:   csr_apply = old | wdata;
      CSR_OP_CLEAR: csr_apply = old & ~wdata;
      default:      csr_apply = old;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_cx_resp_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ibex_cx_resp_mux                                            |
// | Brief  : Picks valid/err/data of one unit from flattened resp buses  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ibex_cx_resp_mux
  import ibex_cx_ctrl_pkg::*;
#(
  parameter int NumCx = 4
) (
  input  logic [CX_IDX_ID_W-1:0] sel_i,
  input  logic [NumCx-1:0]       valid_i,
  input  logic [NumCx-1:0]       err_i,
  input  logic [32*NumCx-1:0]    data_i,
  output logic                   valid_o,
  output logic                   err_o,
  output logic [31:0]            data_o
);

  always_comb begin
    valid_o = 1'b0;
    err_o   = 1'b0;
    data_o  = 32'd0;
    for (int k = 0; k < NumCx; k++) begin
      if (sel_i == CX_IDX_ID_W'(k)) begin
        valid_o = valid_i[k];
        err_o   = err_i[k];
        data_o  = data_i[32*k +: 32];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ibex_cx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ibex_cx_ctrl                                                |
// | Brief  : CX CSRs, enable check and req/resp dispatch to CX units     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ibex_cx_ctrl
  import ibex_cx_ctrl_pkg::*;
#(
  parameter int NumCx         = 4,
  parameter int NumStates     = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_access_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [1:0]           csr_op_i,
  input  logic [31:0]          csr_wdata_i,
  input  logic [1:0]           priv_lvl_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_illegal_o,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [9:0]           instr_funct_i,
  input  logic [31:0]          op_a_i,
  input  logic [31:0]          op_b_i,
  output logic                 result_valid_o,
  output logic [31:0]          result_o,
  output logic                 result_err_o,
  output logic                 illegal_o,
  output logic [NumCx-1:0]     cx_req_o,
  output logic [7:0]           cx_state_id_o,
  output logic [9:0]           cx_funct_o,
  output logic [31:0]          cx_op_a_o,
  output logic [31:0]          cx_op_b_o,
  input  logic [NumCx-1:0]     cx_resp_valid_i,
  input  logic [NumCx-1:0]     cx_resp_err_i,
  input  logic [32*NumCx-1:0]  cx_resp_data_i
);

  localparam int          CNT_W   = $clog2(TimeoutCycles);
  localparam logic [31:0] EN_MASK = (NumCx >= 32) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << NumCx) - 64'd1);

  cx_state_e               r_state;
  logic                    r_ready;
  logic [NumCx-1:0]        r_req;
  logic [CX_IDX_ID_W-1:0]  r_cx_id;
  logic [7:0]              r_state_id;
  logic [9:0]              r_funct;
  logic [31:0]             r_op_a;
  logic [31:0]             r_op_b;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_valid;
  logic [31:0]             r_result;
  logic                    r_err;
  logic [CX_IDX_W-1:0]     r_cx_idx;
  logic [CX_IDX_W-1:0]     r_mcx_idx;
  logic [31:0]             r_mcx_en;
  logic [3:1]              r_stat_err;

  logic [CX_IDX_ID_W-1:0]  w_cx_id;
  logic [7:0]              w_st_id;
  logic                    w_in_range;
  logic                    w_enabled;
  logic                    w_issue;
  logic                    w_accept;
  logic [NumCx-1:0]        w_onehot;
  logic                    w_sel_valid;
  logic                    w_sel_err;
  logic [31:0]             w_sel_data;
  logic                    w_resp;
  logic                    w_timeout;
  logic                    w_csr_we;
  logic [31:0]             w_csr_new;
  logic [3:1]              w_stat_clr;
  logic [3:1]              w_stat_set;

  assign w_cx_id    = r_cx_idx[CX_IDX_ID_W-1:0];
  assign w_st_id    = r_cx_idx[CX_IDX_W-1:CX_IDX_ID_W];
  assign w_in_range = ({1'b0, w_cx_id} < 9'(NumCx)) && ({1'b0, w_st_id} < 9'(NumStates));
  assign w_enabled  = (w_cx_id < 8'd32) && r_mcx_en[w_cx_id[4:0]];
  assign w_issue    = (r_state == CX_IDLE) && instr_valid_i;
  assign w_accept   = w_issue && w_in_range && w_enabled;
  assign illegal_o  = w_issue && !(w_in_range && w_enabled);

  for (genvar k = 0; k < NumCx; k++) begin : g_onehot
    assign w_onehot[k] = (w_cx_id == CX_IDX_ID_W'(k));
  end

  // Selection uses the latched id so CSR writes during WAIT cannot redirect it.
  ibex_cx_resp_mux #(
    .NumCx   (NumCx)
  ) u_resp_mux (
    .sel_i   (r_cx_id),
    .valid_i (cx_resp_valid_i),
    .err_i   (cx_resp_err_i),
    .data_i  (cx_resp_data_i),
    .valid_o (w_sel_valid),
    .err_o   (w_sel_err),
    .data_o  (w_sel_data)
  );

  assign w_resp    = (r_state == CX_WAIT) && w_sel_valid;
  assign w_timeout = (r_state == CX_WAIT) && !w_sel_valid &&
                     (r_cnt == CNT_W'(TimeoutCycles - 1));

  always_comb begin
    csr_rdata_o = 32'd0;
    case (csr_addr_i)
      CSR_CX_IDX:  csr_rdata_o = {16'd0, r_cx_idx};
      CSR_CX_STAT: csr_rdata_o = {28'd0, r_stat_err, (r_state != CX_IDLE)};
      CSR_MCX_EN:  csr_rdata_o = r_mcx_en;
      CSR_MCX_IDX: csr_rdata_o = {16'd0, r_mcx_idx};
      default:     csr_rdata_o = 32'd0;
    endcase
  end

  assign csr_illegal_o = csr_access_i && (priv_lvl_i != PRIV_LVL_M) &&
                         ((csr_addr_i == CSR_MCX_EN) || (csr_addr_i == CSR_MCX_IDX));
  assign w_csr_we      = csr_access_i && !csr_illegal_o && (csr_op_i != CSR_OP_NONE);
  assign w_csr_new     = csr_apply(csr_op_i, csr_rdata_o, csr_wdata_i);
  assign w_stat_clr    = (w_csr_we && (csr_addr_i == CSR_CX_STAT) &&
                          ((csr_op_i == CSR_OP_WRITE) || (csr_op_i == CSR_OP_CLEAR)))
                         ? csr_wdata_i[3:1] : 3'b000;
  assign w_stat_set    = {w_resp && w_sel_err, w_timeout, illegal_o};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cx_idx   <= '0;
      r_mcx_idx  <= '0;
      r_mcx_en   <= '0;
      r_stat_err <= '0;
    end else begin
      if (w_csr_we && (csr_addr_i == CSR_CX_IDX)) r_cx_idx <= w_csr_new[CX_IDX_W-1:0];
      if (w_csr_we && (csr_addr_i == CSR_MCX_EN)) r_mcx_en <= w_csr_new & EN_MASK;
      if (w_accept) r_mcx_idx <= r_cx_idx;
      // Setting after clearing lets a same-cycle error win over W1C.
      r_stat_err <= (r_stat_err & ~w_stat_clr) | w_stat_set;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= CX_IDLE;
      r_ready    <= 1'b1;
      r_req      <= '0;
      r_cx_id    <= '0;
      r_state_id <= '0;
      r_funct    <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        CX_IDLE: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_state    <= CX_WAIT;
            r_ready    <= 1'b0;
            r_req      <= w_onehot;
            r_cx_id    <= w_cx_id;
            r_state_id <= w_st_id;
            r_funct    <= instr_funct_i;
            r_op_a     <= op_a_i;
            r_op_b     <= op_b_i;
            r_cnt      <= '0;
          end
        end
        CX_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_resp) begin
            r_state  <= CX_DONE;
            r_req    <= '0;
            r_valid  <= 1'b1;
            r_result <= w_sel_data;
            r_err    <= w_sel_err;
          end else if (w_timeout) begin
            r_state  <= CX_DONE;
            r_req    <= '0;
            r_valid  <= 1'b1;
            r_result <= 32'd0;
            r_err    <= 1'b1;
          end
        end
        CX_DONE: begin
          r_state <= CX_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= CX_IDLE;
          r_ready <= 1'b1;
          r_req   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready_o  = r_ready;
  assign cx_req_o       = r_req;
  assign cx_state_id_o  = r_state_id;
  assign cx_funct_o     = r_funct;
  assign cx_op_a_o      = r_op_a;
  assign cx_op_b_o      = r_op_b;
  assign result_valid_o = r_valid;
  assign result_o       = r_result;
  assign result_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ibex_cx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ibex_cx_ctrl                                             |
// | Brief  : Directed scoreboard bench for the CX controller             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ibex_cx_ctrl;

  localparam int          NCX    = 4;
  localparam logic [11:0] A_IDX  = 12'h800;
  localparam logic [11:0] A_STAT = 12'h801;
  localparam logic [11:0] A_MIDX = 12'hBC0;
  localparam logic [11:0] A_MEN  = 12'hBC1;
  localparam logic [1:0]  OP_N   = 2'd0;
  localparam logic [1:0]  OP_W   = 2'd1;
  localparam logic [1:0]  OP_S   = 2'd2;
  localparam logic [1:0]  OP_C   = 2'd3;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            csr_access_i = 1'b0;
  logic [11:0]     csr_addr_i = '0;
  logic [1:0]      csr_op_i = '0;
  logic [31:0]     csr_wdata_i = '0;
  logic [1:0]      priv_lvl_i = 2'b11;
  logic [31:0]     csr_rdata_o;
  logic            csr_illegal_o;
  logic            instr_valid_i = 1'b0;
  logic            instr_ready_o;
  logic [9:0]      instr_funct_i = '0;
  logic [31:0]     op_a_i = '0;
  logic [31:0]     op_b_i = '0;
  logic            result_valid_o;
  logic [31:0]     result_o;
  logic            result_err_o;
  logic            illegal_o;
  logic [NCX-1:0]  cx_req_o;
  logic [7:0]      cx_state_id_o;
  logic [9:0]      cx_funct_o;
  logic [31:0]     cx_op_a_o;
  logic [31:0]     cx_op_b_o;
  logic [NCX-1:0]  cx_resp_valid_i = '0;
  logic [NCX-1:0]  cx_resp_err_i = '0;
  logic [32*NCX-1:0] cx_resp_data_i = '0;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic [31:0] rd;
  int          cnt;

  always #5 clk_i = ~clk_i;

  ibex_cx_ctrl #(
    .NumCx         (NCX),
    .NumStates     (4),
    .TimeoutCycles (64)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .csr_access_i    (csr_access_i),
    .csr_addr_i      (csr_addr_i),
    .csr_op_i        (csr_op_i),
    .csr_wdata_i     (csr_wdata_i),
    .priv_lvl_i      (priv_lvl_i),
    .csr_rdata_o     (csr_rdata_o),
    .csr_illegal_o   (csr_illegal_o),
    .instr_valid_i   (instr_valid_i),
    .instr_ready_o   (instr_ready_o),
    .instr_funct_i   (instr_funct_i),
    .op_a_i          (op_a_i),
    .op_b_i          (op_b_i),
    .result_valid_o  (result_valid_o),
    .result_o        (result_o),
    .result_err_o    (result_err_o),
    .illegal_o       (illegal_o),
    .cx_req_o        (cx_req_o),
    .cx_state_id_o   (cx_state_id_o),
    .cx_funct_o      (cx_funct_o),
    .cx_op_a_o       (cx_op_a_o),
    .cx_op_b_o       (cx_op_b_o),
    .cx_resp_valid_i (cx_resp_valid_i),
    .cx_resp_err_i   (cx_resp_err_i),
    .cx_resp_data_i  (cx_resp_data_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [1:0] op,
                           input logic [31:0] d, input logic [1:0] priv);
    csr_access_i = 1'b1; csr_addr_i = a; csr_op_i = op; csr_wdata_i = d; priv_lvl_i = priv;
    tick();
    csr_access_i = 1'b0; csr_op_i = OP_N; csr_wdata_i = '0; priv_lvl_i = 2'b11;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_access_i = 1'b1; csr_addr_i = a; csr_op_i = OP_N; priv_lvl_i = 2'b11;
    #1;
    d = csr_rdata_o;
    csr_access_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [9:0] f);
    instr_valid_i = 1'b1; op_a_i = a; op_b_i = b; instr_funct_i = f;
    #1;
    check("issue_ready", 32'(instr_ready_o), 32'd1);
    check("issue_no_illegal", 32'(illegal_o), 32'd0);
    @(posedge clk_i);
    #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic set_resp(input int u, input logic [31:0] d, input logic e);
    cx_resp_valid_i = '0; cx_resp_err_i = '0; cx_resp_data_i = '0;
    cx_resp_valid_i[u] = 1'b1;
    cx_resp_err_i[u]   = e;
    cx_resp_data_i[u*32 +: 32] = d;
  endtask

  task automatic clr_resp();
    cx_resp_valid_i = '0; cx_resp_err_i = '0; cx_resp_data_i = '0;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && result_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(result_valid_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_data", result_o, mon_e[31:0]);
        check("result_err", 32'(result_err_o), 32'(mon_e[32]));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(instr_ready_o), 32'd1);
    check("rst_req", 32'(cx_req_o), 32'd0);
    check("rst_valid", 32'(result_valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_funct", 32'(cx_funct_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    csr_read(A_IDX, rd);  check("rst_cx_idx", rd, 32'd0);
    csr_read(A_STAT, rd); check("rst_cx_stat", rd, 32'd0);
    csr_read(A_MEN, rd);  check("rst_mcx_en", rd, 32'd0);
    csr_read(A_MIDX, rd); check("rst_mcx_idx", rd, 32'd0);

    // disabled unit -> illegal pulse, sticky err_disabled
    instr_valid_i = 1'b1;
    #1;
    check("dis_illegal", 32'(illegal_o), 32'd1);
    tick();
    instr_valid_i = 1'b0;
    #1;
    check("dis_illegal_gone", 32'(illegal_o), 32'd0);
    check("dis_no_req", 32'(cx_req_o), 32'd0);
    check("dis_ready", 32'(instr_ready_o), 32'd1);
    csr_read(A_STAT, rd); check("dis_stat", rd, 32'h2);

    // set beats W1C in the same cycle
    instr_valid_i = 1'b1;
    csr_access_i = 1'b1; csr_addr_i = A_STAT; csr_op_i = OP_C; csr_wdata_i = 32'h2;
    #1;
    check("setwin_illegal", 32'(illegal_o), 32'd1);
    tick();
    instr_valid_i = 1'b0; csr_access_i = 1'b0; csr_op_i = OP_N;
    csr_read(A_STAT, rd); check("setwin_stat", rd, 32'h2);
    csr_write(A_STAT, OP_S, 32'hE, 2'b11);
    csr_read(A_STAT, rd); check("stat_set_ignored", rd, 32'h2);
    csr_write(A_STAT, OP_C, 32'h2, 2'b11);
    csr_read(A_STAT, rd); check("stat_clear", rd, 32'h0);

    csr_write(A_MEN, OP_W, 32'hFF, 2'b11);
    csr_read(A_MEN, rd); check("men_mask", rd, 32'hF);
    csr_write(A_MEN, OP_W, 32'h4, 2'b11);
    csr_write(A_IDX, OP_W, 32'hFFFF_0302, 2'b11);
    csr_read(A_IDX, rd); check("idx_fields", rd, 32'h0302);

    // unit 2, state 3, answers in the third WAIT cycle
    exp_q.push_back({1'b0, 32'hC});
    issue(32'd5, 32'd7, 10'h155);
    check("d_req1", 32'(cx_req_o), 32'h4);
    check("d_state_id", 32'(cx_state_id_o), 32'd3);
    check("d_funct", 32'(cx_funct_o), 32'h155);
    check("d_op_a", cx_op_a_o, 32'd5);
    check("d_op_b", cx_op_b_o, 32'd7);
    check("d_ready_low", 32'(instr_ready_o), 32'd0);
    csr_read(A_STAT, rd); check("d_busy", rd, 32'h1);
    tick();
    check("d_req2", 32'(cx_req_o), 32'h4);
    tick();
    check("d_req3", 32'(cx_req_o), 32'h4);
    check("d_no_valid_yet", 32'(result_valid_o), 32'd0);
    set_resp(2, 32'hC, 1'b0);
    tick();
    clr_resp();
    check("d_req_drop", 32'(cx_req_o), 32'd0);
    check("d_valid", 32'(result_valid_o), 32'd1);
    tick();
    check("d_valid_pulse", 32'(result_valid_o), 32'd0);
    csr_read(A_MIDX, rd); check("d_mcx_idx", rd, 32'h0302);

    // unit 2 silent -> timeout after 64 req cycles
    csr_write(A_IDX, OP_W, 32'h2, 2'b11);
    exp_q.push_back({1'b1, 32'h0});
    issue(32'd1, 32'd2, 10'h3);
    cnt = 0;
    while (cx_req_o !== '0 && cnt < 200) begin
      cnt++;
      tick();
    end
    check("to_req_cycles", 32'(cnt), 32'd64);
    check("to_valid", 32'(result_valid_o), 32'd1);
    tick();
    csr_read(A_STAT, rd); check("to_stat", rd, 32'h4);
    csr_write(A_STAT, OP_W, 32'h4, 2'b11);
    csr_read(A_STAT, rd); check("to_stat_w1c", rd, 32'h0);

    // non-selected response ignored; selected error response
    csr_write(A_MEN, OP_S, 32'h3, 2'b11);
    csr_write(A_IDX, OP_W, 32'h0, 2'b11);
    exp_q.push_back({1'b1, 32'h55});
    issue(32'd9, 32'd9, 10'h0);
    set_resp(1, 32'hDEAD, 1'b0);
    tick();
    check("ign_req", 32'(cx_req_o), 32'h1);
    check("ign_valid", 32'(result_valid_o), 32'd0);
    set_resp(0, 32'h55, 1'b1);
    tick();
    clr_resp();
    check("er_valid", 32'(result_valid_o), 32'd1);
    tick();
    csr_read(A_STAT, rd); check("er_stat", rd, 32'h8);
    csr_write(A_STAT, OP_C, 32'h8, 2'b11);

    // M-only CSR from U-mode
    csr_access_i = 1'b1; csr_addr_i = A_MEN; csr_op_i = OP_W; csr_wdata_i = 32'h0; priv_lvl_i = 2'b00;
    #1;
    check("u_men_illegal", 32'(csr_illegal_o), 32'd1);
    tick();
    csr_addr_i = A_IDX; csr_op_i = OP_N;
    #1;
    check("u_idx_legal", 32'(csr_illegal_o), 32'd0);
    csr_access_i = 1'b0; priv_lvl_i = 2'b11;
    csr_read(A_MEN, rd); check("u_men_unchanged", rd, 32'h7);

    // CSR changes during WAIT leave the in-flight op alone
    csr_write(A_IDX, OP_W, 32'h1, 2'b11);
    exp_q.push_back({1'b0, 32'h1234});
    issue(32'd3, 32'd4, 10'h2A);
    csr_write(A_MEN, OP_W, 32'h0, 2'b11);
    csr_write(A_IDX, OP_W, 32'h3, 2'b11);
    check("inflight_req", 32'(cx_req_o), 32'h2);
    set_resp(1, 32'h1234, 1'b0);
    tick();
    clr_resp();
    check("inflight_valid", 32'(result_valid_o), 32'd1);
    tick();
    csr_read(A_MEN, rd);  check("inflight_men", rd, 32'h0);
    csr_read(A_MIDX, rd); check("inflight_midx", rd, 32'h0001);

    // state_id and cx_id out of range
    csr_write(A_MEN, OP_W, 32'hF, 2'b11);
    csr_write(A_IDX, OP_W, 32'h0400, 2'b11);
    instr_valid_i = 1'b1;
    #1;
    check("oor_state", 32'(illegal_o), 32'd1);
    csr_write(A_IDX, OP_W, 32'h0004, 2'b11);
    #1;
    check("oor_id", 32'(illegal_o), 32'd1);
    tick();
    instr_valid_i = 1'b0;
    check("oor_no_req", 32'(cx_req_o), 32'd0);
    csr_write(A_STAT, OP_W, 32'hF, 2'b11);

    // minimum latency and back-to-back issue
    csr_write(A_IDX, OP_W, 32'h0, 2'b11);
    exp_q.push_back({1'b0, 32'hAB});
    issue(32'd0, 32'd0, 10'h1);
    set_resp(0, 32'hAB, 1'b0);
    tick();
    clr_resp();
    check("min_lat_valid", 32'(result_valid_o), 32'd1);
    check("done_not_ready", 32'(instr_ready_o), 32'd0);
    tick();
    exp_q.push_back({1'b0, 32'hCD});
    issue(32'd0, 32'd0, 10'h2);
    set_resp(0, 32'hCD, 1'b0);
    tick();
    clr_resp();
    tick();

    // reset in WAIT drops req asynchronously
    csr_write(A_IDX, OP_W, 32'h0100, 2'b11);
    issue(32'd0, 32'd0, 10'h0);
    check("rw_req_before", 32'(cx_req_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rw_req_async", 32'(cx_req_o), 32'd0);
    check("rw_ready", 32'(instr_ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    csr_read(A_IDX, rd);  check("rw_cx_idx", rd, 32'd0);
    csr_read(A_STAT, rd); check("rw_cx_stat", rd, 32'd0);
    csr_read(A_MEN, rd);  check("rw_mcx_en", rd, 32'd0);
    csr_read(A_MIDX, rd); check("rw_mcx_idx", rd, 32'd0);
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
